// File: rtl/gates_bist_pkg.sv
// Shared types, constants and golden model for the gates BIST engine.
package gates_bist_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StDrive,
      StCheck,
      StDone
   } state_e;

   // Bit positions inside the 7-bit gates response vector.
   localparam int unsigned RESP_AND  = 0;
   localparam int unsigned RESP_OR   = 1;
   localparam int unsigned RESP_NOT  = 2;
   localparam int unsigned RESP_XOR  = 3;
   localparam int unsigned RESP_NAND = 4;
   localparam int unsigned RESP_NOR  = 5;
   localparam int unsigned RESP_XNOR = 6;

   // x^8+x^6+x^5+x^4+1 on a left-shifting register: feedback from bits 7,5,4,3.
   localparam logic [7:0]  LFSR_TAPS = 8'hB8;
   // x^16+x^12+x^5+1, applied when the MISR msb shifts out.
   localparam logic [15:0] MISR_TAPS = 16'h1021;

   // Fault-free response of the gates block for one operand pair.
   function automatic logic [6:0] gates_expect(input logic a, input logic b);
      logic [6:0] r;
      r            = '0;
      r[RESP_AND]  = a & b;
      r[RESP_OR]   = a | b;
      r[RESP_NOT]  = ~a;
      r[RESP_XOR]  = a ^ b;
      r[RESP_NAND] = ~(a & b);
      r[RESP_NOR]  = ~(a | b);
      r[RESP_XNOR] = ~(a ^ b);
      return r;
   endfunction

endpackage

// File: rtl/gates_bist_lfsr.sv
// 8-bit Fibonacci LFSR producing the operand pair for the gates block.
module gates_bist_lfsr
   import gates_bist_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       load,
   input  logic [7:0] seed,
   input  logic       step,
   output logic [1:0] operand
);

   logic [7:0] lfsr_q, lfsr_d;
   logic       feedback;

   // Next state: load wins over step; an all-zero seed would lock up, so use 1.
   always_comb begin
      feedback = ^(lfsr_q & LFSR_TAPS);
      lfsr_d   = lfsr_q;
      if (load) begin
         lfsr_d = (seed == 8'h00) ? 8'h01 : seed;
      end else if (step) begin
         lfsr_d = {lfsr_q[6:0], feedback};
      end
   end

   // State register; resets to zero so the operands read 0 until the first load.
   always_ff @(posedge clk) begin
      if (rst) begin
         lfsr_q <= 8'h00;
      end else begin
         lfsr_q <= lfsr_d;
      end
   end

   assign operand = lfsr_q[1:0];

endmodule

// File: rtl/gates_bist.sv
// Built-in self-test engine for the two-input gates block.
// Optional feature: define GATES_BIST_MISR_EN to build the 16-bit response MISR;
// otherwise signature is tied to zero.
module gates_bist
   import gates_bist_pkg::*;
#(
   parameter int unsigned NUM_VECTORS = 16,
   parameter logic [7:0]  LFSR_SEED   = 8'hA5
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   output logic        a,
   output logic        b,
   input  logic [6:0]  resp,
   output logic        busy,
   output logic        done,
   output logic        pass,
   output logic [7:0]  err_count,
   output logic [15:0] vec_count,
   output logic [15:0] signature
);

   localparam logic [15:0] LastVec = 16'(NUM_VECTORS - 1);

   state_e      state_q, state_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic [7:0]  err_q, err_d;
   logic [15:0] vec_q, vec_d;
   logic        lfsr_load, lfsr_step;
   logic [1:0]  lfsr_op;
   logic        mismatch;

   gates_bist_lfsr u_lfsr (
      .clk     (clk),
      .rst     (rst),
      .load    (lfsr_load),
      .seed    (LFSR_SEED),
      .step    (lfsr_step),
      .operand (lfsr_op)
   );

   assign a = lfsr_op[0];
   assign b = lfsr_op[1];

   // Case inequality so X/Z on the response is reported as a failure.
   assign mismatch = (resp !== gates_expect(a, b));

   // Next-state and counter updates for the run sequencer.
   always_comb begin
      state_d   = state_q;
      busy_d    = busy_q;
      done_d    = done_q;
      err_d     = err_q;
      vec_d     = vec_q;
      lfsr_load = 1'b0;
      lfsr_step = 1'b0;
      unique case (state_q)
         StIdle, StDone: begin
            if (start) begin
               state_d   = StDrive;
               lfsr_load = 1'b1;
               busy_d    = 1'b1;
               done_d    = 1'b0;
               err_d     = 8'd0;
               vec_d     = 16'd0;
            end else if (state_q == StDone) begin
               // Completion flags are published one edge after entering DONE.
               busy_d = 1'b0;
               done_d = 1'b1;
            end
         end
         StDrive: begin
            state_d = StCheck;
         end
         StCheck: begin
            if (mismatch && (err_q != 8'hFF)) begin
               err_d = err_q + 8'd1;
            end
            vec_d     = vec_q + 16'd1;
            lfsr_step = 1'b1;
            state_d   = (vec_q == LastVec) ? StDone : StDrive;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // Sequencer and result registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 8'd0;
         vec_q   <= 16'd0;
      end else begin
         state_q <= state_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         err_q   <= err_d;
         vec_q   <= vec_d;
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign pass      = done_q && (err_q == 8'd0);
   assign err_count = err_q;
   assign vec_count = vec_q;

`ifdef GATES_BIST_MISR_EN
   logic [15:0] misr_q;
   logic        misr_clear;
   logic        misr_en;

   assign misr_clear = start && ((state_q == StIdle) || (state_q == StDone));
   assign misr_en    = (state_q == StCheck);

   // Galois-style MISR compressing each checked response into the low bits.
   always_ff @(posedge clk) begin
      if (rst || misr_clear) begin
         misr_q <= 16'h0000;
      end else if (misr_en) begin
         misr_q <= {misr_q[14:0], 1'b0} ^ (misr_q[15] ? MISR_TAPS : 16'h0000)
                   ^ {9'b0, resp};
      end
   end

   assign signature = misr_q;
`else
   assign signature = 16'h0000;
`endif

endmodule

// File: tb/tb_gates_bist.sv
// Self-checking bench for gates_bist: three instances (default, 300 vectors,
// zero seed) driven by a fault-injecting gates model and checked against a
// behavioural reference of the LFSR sequence, error count and MISR.
module tb_gates_bist;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        start_w [3];
   logic        a_w     [3];
   logic        b_w     [3];
   logic [6:0]  resp_w  [3];
   logic        busy_w  [3];
   logic        done_w  [3];
   logic        pass_w  [3];
   logic [7:0]  err_w   [3];
   logic [15:0] vec_w   [3];
   logic [15:0] sig_w   [3];
   int          mode    [3];
   int          fbit    [3];

   int checks = 0;
   int errors = 0;

   // Fault modes: 0 none, 1 invert bit, 2 stuck-at-0, 3 stuck-at-1, 4 X on bit.
   function automatic logic [6:0] good_resp(input logic a, input logic b);
      return {~(a ^ b), ~(a | b), ~(a & b), a ^ b, ~a, a | b, a & b};
   endfunction

   function automatic logic [6:0] faulty(input logic [6:0] g, input int m, input int k);
      logic [6:0] r;
      r = g;
      case (m)
         1: r[k] = ~g[k];
         2: r[k] = 1'b0;
         3: r[k] = 1'b1;
         4: r[k] = 1'bx;
         default: r = g;
      endcase
      return r;
   endfunction

   function automatic logic [7:0] lfsr_next(input logic [7:0] l);
      return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
   endfunction

   assign resp_w[0] = faulty(good_resp(a_w[0], b_w[0]), mode[0], fbit[0]);
   assign resp_w[1] = faulty(good_resp(a_w[1], b_w[1]), mode[1], fbit[1]);
   assign resp_w[2] = faulty(good_resp(a_w[2], b_w[2]), mode[2], fbit[2]);

   gates_bist #(.NUM_VECTORS(16), .LFSR_SEED(8'hA5)) u_main (
      .clk(clk), .rst(rst), .start(start_w[0]), .a(a_w[0]), .b(b_w[0]), .resp(resp_w[0]),
      .busy(busy_w[0]), .done(done_w[0]), .pass(pass_w[0]), .err_count(err_w[0]),
      .vec_count(vec_w[0]), .signature(sig_w[0])
   );

   gates_bist #(.NUM_VECTORS(300), .LFSR_SEED(8'hA5)) u_long (
      .clk(clk), .rst(rst), .start(start_w[1]), .a(a_w[1]), .b(b_w[1]), .resp(resp_w[1]),
      .busy(busy_w[1]), .done(done_w[1]), .pass(pass_w[1]), .err_count(err_w[1]),
      .vec_count(vec_w[1]), .signature(sig_w[1])
   );

   gates_bist #(.NUM_VECTORS(16), .LFSR_SEED(8'h00)) u_seed0 (
      .clk(clk), .rst(rst), .start(start_w[2]), .a(a_w[2]), .b(b_w[2]), .resp(resp_w[2]),
      .busy(busy_w[2]), .done(done_w[2]), .pass(pass_w[2]), .err_count(err_w[2]),
      .vec_count(vec_w[2]), .signature(sig_w[2])
   );

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference: walk the operand sequence and count faulty vectors.
   task automatic compute_expect(input logic [7:0] seed, input int nvec, input int m,
                                 input int k, output int err, output logic [15:0] sig);
      logic [7:0] l;
      logic [6:0] g, f;
      l   = (seed == 8'h00) ? 8'h01 : seed;
      err = 0;
      sig = 16'h0000;
      for (int i = 0; i < nvec; i++) begin
         g = good_resp(l[0], l[1]);
         f = faulty(g, m, k);
         if ((f !== g) && (err < 255)) err++;
         sig = {sig[14:0], 1'b0} ^ (sig[15] ? 16'h1021 : 16'h0000) ^ {9'b0, f};
         l = lfsr_next(l);
      end
   endtask

   // One complete run on instance s; r is the edge index at which start is
   // re-pulsed mid-run (0 = none).
   task automatic run_vec(input int s, input int nvec, input logic [7:0] seed, input int r,
                          input string tag);
      int          exp_err;
      logic [15:0] exp_sig;
      int          lat;
      logic [7:0]  ml;
      compute_expect(seed, nvec, mode[s], fbit[s], exp_err, exp_sig);
      ml  = (seed == 8'h00) ? 8'h01 : seed;
      lat = -1;
      @(negedge clk) start_w[s] = 1'b1;
      @(posedge clk); #1;
      start_w[s] = 1'b0;
      check_val({tag, "_busy_go"}, 32'(busy_w[s]), 32'd1);
      check_val({tag, "_done_clr"}, 32'(done_w[s]), 32'd0);
      for (int n = 1; n <= 2 * nvec + 10; n++) begin
         @(negedge clk) start_w[s] = (n == r);
         @(posedge clk); #1;
         if ((n % 2 == 1) && ((n - 1) / 2 < nvec)) begin
            check_val({tag, "_ab"}, 32'({b_w[s], a_w[s]}), 32'(ml[1:0]));
            ml = lfsr_next(ml);
`ifndef GATES_BIST_MISR_EN
            check_val({tag, "_sig0"}, 32'(sig_w[s]), 32'd0);
`endif
         end
         if (done_w[s] === 1'b1) begin
            lat = n;
            break;
         end
      end
      start_w[s] = 1'b0;
      check_val({tag, "_done_lat"}, lat, 2 * nvec + 1);
      check_val({tag, "_vec"}, 32'(vec_w[s]), nvec);
      check_val({tag, "_err"}, 32'(err_w[s]), exp_err);
      check_val({tag, "_pass"}, 32'(pass_w[s]), 32'(exp_err == 0));
      check_val({tag, "_busy_end"}, 32'(busy_w[s]), 32'd0);
`ifdef GATES_BIST_MISR_EN
      if (mode[s] != 4) check_val({tag, "_sig"}, 32'(sig_w[s]), 32'(exp_sig));
`else
      check_val({tag, "_sig"}, 32'(sig_w[s]), 32'd0);
`endif
      @(posedge clk); #1;
      check_val({tag, "_done_hold"}, 32'(done_w[s]), 32'd1);
   endtask

   task automatic check_reset_state(input string tag);
      check_val({tag, "_ab"}, 32'({b_w[0], a_w[0]}), 32'd0);
      check_val({tag, "_busy"}, 32'(busy_w[0]), 32'd0);
      check_val({tag, "_done"}, 32'(done_w[0]), 32'd0);
      check_val({tag, "_pass"}, 32'(pass_w[0]), 32'd0);
      check_val({tag, "_err"}, 32'(err_w[0]), 32'd0);
      check_val({tag, "_vec"}, 32'(vec_w[0]), 32'd0);
      check_val({tag, "_sig"}, 32'(sig_w[0]), 32'd0);
   endtask

   task automatic mid_run_reset(input int cyc, input string tag);
      @(negedge clk) start_w[0] = 1'b1;
      @(posedge clk); #1;
      start_w[0] = 1'b0;
      repeat (cyc) @(posedge clk);
      // Reset and start together: reset must win.
      @(negedge clk) begin
         rst        = 1'b1;
         start_w[0] = 1'b1;
      end
      @(posedge clk); #1;
      check_reset_state(tag);
      @(negedge clk) begin
         rst        = 1'b0;
         start_w[0] = 1'b0;
      end
      @(posedge clk); #1;
      check_val({tag, "_idle"}, 32'(busy_w[0]), 32'd0);
   endtask

   initial begin
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         start_w[i] = 1'b0;
         mode[i]    = 0;
         fbit[i]    = 0;
      end
      repeat (3) @(posedge clk);
      #1;
      check_reset_state("rst_hold");
      @(negedge clk) rst = 1'b0;
      @(posedge clk); #1;
      check_reset_state("rst_rel");

      // Fault-free, xor inverted, and stuck-at-0.
      run_vec(0, 16, 8'hA5, 0, "clean");
      mode[0] = 1; fbit[0] = 3;
      run_vec(0, 16, 8'hA5, 0, "xor_inv");
      mode[0] = 2; fbit[0] = 0;
      run_vec(0, 16, 8'hA5, 0, "and_sa0");

      // Randomized fault kinds, bits, and mid-run start re-pulses.
      for (int t = 0; t < 8; t++) begin
         mode[0] = int'($urandom_range(0, 4));
         fbit[0] = int'($urandom_range(0, 6));
         run_vec(0, 16, 8'hA5, ($urandom_range(0, 1) == 1) ? int'($urandom_range(2, 32)) : 0,
                 "rand");
      end

      // Reset mid-run at cycle 10 and at a random cycle, each followed by a clean run.
      mode[0] = 0;
      mid_run_reset(10, "rst_mid10");
      run_vec(0, 16, 8'hA5, 0, "post_rst");
      mid_run_reset(int'($urandom_range(2, 30)), "rst_mid_rand");
      run_vec(0, 16, 8'hA5, 0, "post_rst2");

      // Saturation on a 300-vector run with the not output inverted.
      mode[1] = 1; fbit[1] = 2;
      run_vec(1, 300, 8'hA5, 0, "long_sat");

      // Zero seed substitutes 8'h01.
      run_vec(2, 16, 8'h00, 0, "seed0");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
